riscv_commit_checker: RTL

Synthesizable, parametrised self-check block for the riscv_pipeline top. It snoops register-file writebacks and data-memory stores, and holds a programmable table of NUM_CHECKS expected register and memory values. When a halt event or a timeout occurs, it walks the table and reports pass/fail, the error count and the first failing entry. It replaces fixed-cycle final-state checking with event-driven checking that works on silicon and FPGA as well as in simulation.

---
 rtl/riscv_chk_pkg.sv | 32 +++
 rtl/riscv_chk_table.sv | 65 ++++++
 rtl/riscv_commit_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/riscv_chk_pkg.sv
// Shared types for the commit checker: entry kinds, FSM states and the table entry layout.
package riscv_chk_pkg;

    localparam int CHK_XLEN = 32;

    typedef enum logic {
        CHK_REG = 1'b0,
        CHK_MEM = 1'b1
    } chk_kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_EVAL = 2'd2,
        S_DONE = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic                valid;
        chk_kind_e           kind;
        logic [CHK_XLEN-1:0] addr;
        logic [CHK_XLEN-1:0] exp;
        logic [CHK_XLEN-1:0] obs;
        logic                seen;
    } chk_entry_t;

    // An enabled entry fails when nothing was observed or the last observation differs.
    function automatic logic entry_fails(input chk_entry_t e);
        return e.valid && (!e.seen || (e.obs != e.exp));
    endfunction

endpackage

// File: rtl/riscv_chk_table.sv
// Expected-value table: configuration writes, snoop capture of writebacks/stores, EVAL read port.
module riscv_chk_table
    import riscv_chk_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_CHECKS = 8,
    parameter int IDX_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_kind,
    input  logic [XLEN-1:0]  cfg_addr,
    input  logic [XLEN-1:0]  cfg_data,
    input  logic             cfg_valid,
    input  logic             clear_seen,
    input  logic             cap_en,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             st_en,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    input  logic [IDX_W-1:0] rd_idx,
    output chk_entry_t       rd_entry
);

    chk_entry_t tbl [NUM_CHECKS];

    assign rd_entry = tbl[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    tbl[i].valid <= cfg_valid;
                    tbl[i].kind  <= chk_kind_e'(cfg_kind);
                    tbl[i].addr  <= cfg_addr;
                    tbl[i].exp   <= cfg_data;
                end
                if (clear_seen) begin
                    tbl[i].seen <= 1'b0;
                end
                // x0 writes are architecturally discarded, so they never satisfy a check.
                if (cap_en && tbl[i].valid) begin
                    if ((tbl[i].kind == CHK_REG) && wb_en && (wb_rd != 5'd0) &&
                        (tbl[i].addr[4:0] == wb_rd)) begin
                        tbl[i].obs  <= wb_data;
                        tbl[i].seen <= 1'b1;
                    end
                    if ((tbl[i].kind == CHK_MEM) && st_en && (tbl[i].addr == st_addr)) begin
                        tbl[i].obs  <= st_data;
                        tbl[i].seen <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/riscv_commit_checker.sv
// Event-driven final-state checker: snoops commits during RUN, walks the table in EVAL on halt/timeout.
// All inputs are single-cycle strobes sampled on the rising edge; there is no backpressure.
module riscv_commit_checker
    import riscv_chk_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_CHECKS     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_kind,
    input  logic [XLEN-1:0]  cfg_addr,
    input  logic [XLEN-1:0]  cfg_data,
    input  logic             cfg_valid,
    input  logic             start,
    input  logic             halt,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             st_en,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [IDX_W:0]   err_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output chk_state_e       dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHECKS - 1);

    chk_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] eval_idx;
    chk_entry_t       rd_entry;
    logic             cfg_ok;
    logic             enter_run;

    assign cfg_ok    = (state == S_IDLE) || (state == S_DONE);
    assign enter_run = cfg_ok && start;
    assign dbg_state = state;

    riscv_chk_table #(
        .XLEN       (XLEN),
        .NUM_CHECKS (NUM_CHECKS),
        .IDX_W      (IDX_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we && cfg_ok),
        .cfg_idx    (cfg_idx),
        .cfg_kind   (cfg_kind),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .clear_seen (enter_run),
        .cap_en     (state == S_RUN),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .st_en      (st_en),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .rd_idx     (eval_idx),
        .rd_entry   (rd_entry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            eval_idx       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
        end else if (enter_run) begin
            state          <= S_RUN;
            cnt            <= '0;
            eval_idx       <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    // halt takes priority so a program finishing on the last cycle is not a timeout.
                    if (halt) begin
                        state    <= S_EVAL;
                        eval_idx <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= S_EVAL;
                        eval_idx <= '0;
                        timeout  <= 1'b1;
                    end
                end
                S_EVAL: begin
                    if (entry_fails(rd_entry)) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0) begin
                            first_fail_idx <= eval_idx;
                        end
                    end
                    if (eval_idx == IDX_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                    end else begin
                        eval_idx <= eval_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    pass <= (err_count == '0) && !timeout;
                    fail <= !((err_count == '0) && !timeout);
                end
                default: ;
            endcase
        end
    end

endmodule
